// File: rtl/sb_pkg.sv
// Shared constants for the register scoreboard: register count, default
// in-flight depth and the counter width derived from it.
package sb_pkg;

    localparam int NUM_REGS        = 32;
    localparam int MAX_PENDING_DEF = 3;
    localparam int CNT_W           = $clog2(MAX_PENDING_DEF + 1);

    // Width needed to hold counts 0..max inclusive.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill signal bundle between the pipeline and the scoreboard.
// The issue handshake is issue_valid_i with stall_o acting as the inverse of ready.
interface reg_scoreboard_if;
    import sb_pkg::*;

    logic                issue_valid_i;
    logic [4:0]          issue_rs1_addr_i;
    logic [4:0]          issue_rs2_addr_i;
    logic                issue_rs1_used_i;
    logic                issue_rs2_used_i;
    logic [4:0]          issue_rd_addr_i;
    logic                issue_rd_wren_i;
    logic                stall_o;
    logic                wb_valid_i;
    logic [4:0]          wb_rd_addr_i;
    logic                wb_rd_wren_i;
    logic                kill_valid_i;
    logic [4:0]          kill_rd_addr_i;
    logic [NUM_REGS-1:0] busy_o;
    logic                err_o;

    modport master (
        output issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i, issue_rd_wren_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_wren_i, kill_valid_i, kill_rd_addr_i,
        input  stall_o, busy_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i, issue_rd_wren_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_wren_i, kill_valid_i, kill_rd_addr_i,
        output stall_o, busy_o, err_o
    );

endinterface

// File: rtl/sb_counter.sv
// Saturating up/down pending counter: one increment and up to two decrements
// netted into a single update; err pulses when the result had to be clamped.
module sb_counter
    import sb_pkg::*;
#(
    parameter int MAX = MAX_PENDING_DEF,
    parameter int W   = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic [1:0]   dec,
    output logic [W-1:0] count,
    output logic         err
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_d;
    int           nxt;

    always_comb begin
        count_d = count;
        err     = 1'b0;
        nxt     = int'(count) + int'(inc) - int'(dec[0]) - int'(dec[1]);
        if (nxt < 0) begin
            count_d = '0;
            err     = 1'b1;
        end else if (nxt > MAX) begin
            count_d = MAX_C;
            err     = 1'b1;
        end else begin
            count_d = nxt[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count_d;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writers per architectural register and
// stalls issue on RAW hazards or when a destination already has MAX_PENDING writers.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int MAX_PENDING = MAX_PENDING_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    reg_scoreboard_if.slave bus
);

    localparam int           CW    = cnt_width(MAX_PENDING);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PENDING);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] err_vec;
    logic                err_q;
    logic                stall;
    logic                fire;

    assign fire = bus.issue_valid_i && !stall;

    // x0 is hardwired: never counted, never busy, never an error source.
    assign cnt[0]     = '0;
    assign busy[0]    = 1'b0;
    assign err_vec[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic       inc;
        logic [1:0] dec;

        assign inc    = fire && bus.issue_rd_wren_i && (bus.issue_rd_addr_i == 5'(i));
        assign dec[0] = bus.wb_valid_i && bus.wb_rd_wren_i && (bus.wb_rd_addr_i == 5'(i));
        assign dec[1] = bus.kill_valid_i && (bus.kill_rd_addr_i == 5'(i));

        sb_counter #(
            .MAX (MAX_PENDING),
            .W   (CW)
        ) u_cnt (
            .clk   (clk_i),
            .rst   (rst_i),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[i]),
            .err   (err_vec[i])
        );

        assign busy[i] = |cnt[i];
    end

    // Stall reads registered counts only, so a same-cycle writeback never
    // releases a dependent (no write-to-read bypass in the register file).
    always_comb begin
        stall = 1'b0;
        if (bus.issue_valid_i) begin
            if (bus.issue_rs1_used_i && busy[bus.issue_rs1_addr_i]) stall = 1'b1;
            if (bus.issue_rs2_used_i && busy[bus.issue_rs2_addr_i]) stall = 1'b1;
            if (bus.issue_rd_wren_i && (bus.issue_rd_addr_i != 5'd0) &&
                (cnt[bus.issue_rd_addr_i] == MAX_C)) stall = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_q | (|err_vec);
    end

    assign bus.stall_o = stall;
    assign bus.busy_o  = busy;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard stalls, x0 handling, depth limit,
// netted same-cycle updates, kill, sticky error and asynchronous reset.
module tb_reg_scoreboard;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    reg_scoreboard_if bus ();

    reg_scoreboard #(.MAX_PENDING(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic wr);
        bus.issue_valid_i    = v;
        bus.issue_rs1_addr_i = rs1;
        bus.issue_rs1_used_i = u1;
        bus.issue_rs2_addr_i = rs2;
        bus.issue_rs2_used_i = u2;
        bus.issue_rd_addr_i  = rd;
        bus.issue_rd_wren_i  = wr;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        bus.wb_valid_i   = v;
        bus.wb_rd_addr_i = rd;
        bus.wb_rd_wren_i = v;
    endtask

    task automatic set_kill(input logic v, input logic [4:0] rd);
        bus.kill_valid_i   = v;
        bus.kill_rd_addr_i = rd;
    endtask

    task automatic clear_in();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0);
        set_kill(1'b0, 5'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        clear_in();
        #1;
        check("rst_busy", bus.busy_o, 32'h0);
        check("rst_err", {31'd0, bus.err_o}, 32'd0);
        check("rst_stall_idle", {31'd0, bus.stall_o}, 32'd0);
        set_issue(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1);
        #1;
        check("rst_stall_zero_cnt", {31'd0, bus.stall_o}, 32'd0);
        clear_in();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // RAW on x5, released only the cycle after its writeback
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1 check("x5_first_issue", {31'd0, bus.stall_o}, 32'd0);
        tick();
        clear_in();
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0);
        #1;
        check("x5_reader_stall", {31'd0, bus.stall_o}, 32'd1);
        check("x5_busy", bus.busy_o, 32'h0000_0020);
        tick();
        check("x5_reader_stall2", {31'd0, bus.stall_o}, 32'd1);
        set_wb(1'b1, 5'd5);
        #1 check("x5_no_bypass", {31'd0, bus.stall_o}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        #1;
        check("x5_released", {31'd0, bus.stall_o}, 32'd0);
        check("x5_idle_busy", bus.busy_o, 32'h0);
        tick();
        clear_in();
        #1 check("stall_no_valid", {31'd0, bus.stall_o}, 32'd0);

        // x0 is never tracked
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1 check("x0_write_stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b0);
        #1;
        check("x0_reader_stall", {31'd0, bus.stall_o}, 32'd0);
        check("x0_busy", bus.busy_o, 32'h0);
        tick();
        clear_in();

        // depth limit on x7
        for (int k = 0; k < 3; k++) begin
            set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
            #1 check("x7_fill", {31'd0, bus.stall_o}, 32'd0);
            tick();
        end
        check("x7_full_stall", {31'd0, bus.stall_o}, 32'd1);
        set_wb(1'b1, 5'd7);
        #1 check("x7_full_with_wb", {31'd0, bus.stall_o}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        #1 check("x7_fourth_issues", {31'd0, bus.stall_o}, 32'd0);
        tick();
        clear_in();
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #1 check("x7_full_again", {31'd0, bus.stall_o}, 32'd1);
        clear_in();
        check("x7_busy", bus.busy_o, 32'h0000_0080);
        for (int k = 0; k < 3; k++) begin
            set_wb(1'b1, 5'd7);
            tick();
        end
        clear_in();
        #1;
        check("x7_drained", bus.busy_o, 32'h0);
        check("x7_no_err", {31'd0, bus.err_o}, 32'd0);

        // same-cycle issue and retire of x9 nets to no change
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        set_wb(1'b1, 5'd9);
        #1 check("x9_issue_ok", {31'd0, bus.stall_o}, 32'd0);
        tick();
        clear_in();
        #1 check("x9_net_busy", bus.busy_o, 32'h0000_0200);
        set_wb(1'b1, 5'd9);
        tick();
        clear_in();
        #1 check("x9_drained", bus.busy_o, 32'h0);

        // rs2 hazard only counts when rs2 is used
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        tick();
        set_issue(1'b1, 5'd1, 1'b1, 5'd12, 1'b0, 5'd2, 1'b0);
        #1 check("rs2_unused", {31'd0, bus.stall_o}, 32'd0);
        set_issue(1'b1, 5'd1, 1'b1, 5'd12, 1'b1, 5'd2, 1'b0);
        #1 check("rs2_used_stall", {31'd0, bus.stall_o}, 32'd1);
        clear_in();
        set_kill(1'b1, 5'd12);
        tick();
        clear_in();
        #1 check("x12_killed", bus.busy_o, 32'h0);

        // kill and retire of x3 in the same cycle
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        tick();
        clear_in();
        #1 check("x3_two_pending", bus.busy_o, 32'h0000_0008);
        set_kill(1'b1, 5'd3);
        set_wb(1'b1, 5'd3);
        tick();
        clear_in();
        #1;
        check("x3_kill_wb", bus.busy_o, 32'h0);
        check("x3_no_err", {31'd0, bus.err_o}, 32'd0);

        // underflow on x4 sets a sticky error
        set_wb(1'b1, 5'd4);
        tick();
        clear_in();
        #1;
        check("x4_err", {31'd0, bus.err_o}, 32'd1);
        check("x4_busy", bus.busy_o, 32'h0);
        tick();
        tick();
        check("x4_err_sticky", {31'd0, bus.err_o}, 32'd1);

        // asynchronous reset mid-operation
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        tick();
        clear_in();
        #1 check("x6_busy", bus.busy_o, 32'h0000_0040);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", bus.busy_o, 32'h0);
        check("async_rst_err", {31'd0, bus.err_o}, 32'd0);
        set_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        #1 check("rst_reader_x6", {31'd0, bus.stall_o}, 32'd0);
        clear_in();
        #1 rst = 1'b0;
        tick();
        check("post_rst_busy", bus.busy_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 3, giving the maximum number of in-flight writes tracked per architectural register (range 1..7).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port issue_valid_i, input, 1 bit: decode stage presents an instruction.
REQ-005 SHALL have ports issue_rs1_addr_i / issue_rs2_addr_i, input, 5 bits each: source register indices.
REQ-006 SHALL have ports issue_rs1_used_i / issue_rs2_used_i, input, 1 bit each: the instruction reads that source.
REQ-007 SHALL have port issue_rd_addr_i, input, 5 bits: destination index.
REQ-008 SHALL have port issue_rd_wren_i, input, 1 bit: the instruction writes rd.
REQ-009 SHALL have port stall_o, output, 1 bit: instruction must not issue this cycle.
REQ-010 SHALL have ports wb_valid_i (1 bit), wb_rd_addr_i (5 bits) and wb_rd_wren_i (1 bit), inputs: register-file write occurring at this rising edge.
REQ-011 SHALL have ports kill_valid_i (1 bit) and kill_rd_addr_i (5 bits), inputs: an in-flight writer to rd squashed without writeback.
REQ-012 SHALL have port busy_o, output, 32 bits: bit n set when register n has a pending count of at least 1.
REQ-013 SHALL have port err_o, output, 1 bit: sticky underflow/overflow error flag.

Function
REQ-014 SHALL keep one pending counter per register 1..31, CNT_W bits wide; register 0 is never tracked, and busy_o[0] SHALL be 0.
REQ-015 Issue fires when issue_valid_i=1 and stall_o=0.
REQ-016 On an issue fire with issue_rd_wren_i=1 and rd≠0, the counter of rd SHALL increment at the next edge.
REQ-017 Retire fires when wb_valid_i=1, wb_rd_wren_i=1 and rd≠0; each retire SHALL decrement the counter of rd.
REQ-018 Each kill_valid_i=1 with rd≠0 SHALL decrement the counter of kill_rd_addr_i.
REQ-019 Simultaneous events on the same register SHALL net: +1 issue, −1 retire, −1 kill, applied in one update.
REQ-020 stall_o SHALL be combinational, asserted when issue_valid_i=1 and any of the following holds:
- the counter of a used nonzero source is nonzero;
- issue_rd_wren_i=1, rd≠0, and the counter of rd equals MAX_PENDING.
REQ-021 A retire in the current cycle SHALL NOT clear a stall in that cycle, because the register file has no write-to-read bypass; the dependent instruction issues the cycle after.
REQ-022 stall_o SHALL be 0 whenever issue_valid_i=0.
REQ-023 A decrement that would go below 0 SHALL saturate at 0 and set err_o.
REQ-024 An increment beyond MAX_PENDING (only possible if stall_o is ignored) SHALL saturate and set err_o.
REQ-025 err_o SHALL remain set until reset.
REQ-026 Latency: counter changes SHALL be visible on busy_o and stall_o one cycle after the causing edge.

Reset
REQ-027 While rst_i=1, all counters SHALL be 0 and busy_o=0, err_o=0; stall_o SHALL follow REQ-020 with zero counters.
REQ-028 Reset asserted mid-operation SHALL discard all pending counts immediately; the pipeline is flushed by the same reset.

Structure
REQ-029 Package sb_pkg SHALL hold MAX_PENDING_DEF, CNT_W = $clog2(MAX_PENDING+1), and the NUM_REGS=32 constant.
REQ-030 Sub-module sb_counter SHALL implement one saturating up/down counter with inc, dec[1:0] and err outputs, instantiated 31 times.

Verification
REQ-031 Issue rd=x5 write, next cycle issue reading rs1=x5 -> stall_o=1 until the cycle after the wb of x5, then stall_o=0.
REQ-032 Issue rd=x0, then a reader of x0 -> stall_o never 1, busy_o stays 0.
REQ-033 Three issues to x7 (MAX_PENDING=3), a fourth to x7 -> stall_o=1; one retire of x7 -> fourth issues the following cycle.
REQ-034 Same cycle: issue to x9 plus retire of x9 with count=1 -> count stays 1, busy_o[9]=1.
REQ-035 Retire of x4 with count=0 -> err_o=1 sticky, busy_o[4]=0; rst_i pulse -> err_o=0.
REQ-036 Two writers of x3 pending, kill x3 and retire x3 same cycle -> busy_o[3]=0 next cycle.
